vga_mode_sequencer: RTL and testbench



---
 rtl/vga_mode_pkg.sv | 36 +++
 rtl/vga_mode_rom.sv | 38 +++
 rtl/vga_mode_sequencer.sv | 163 ++++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mode_pkg.sv
// Shared types for the VGA mode sequencer: mode codes,
// sequencer states and the per-mode timing parameter record.
package vga_mode_pkg;

  localparam int MODE_CNT = 6;

  localparam logic [2:0] MODE_640X480   = 3'd0;
  localparam logic [2:0] MODE_800X600   = 3'd1;
  localparam logic [2:0] MODE_1024X768  = 3'd2;
  localparam logic [2:0] MODE_1280X960  = 3'd3;
  localparam logic [2:0] MODE_1280X1024 = 3'd4;
  localparam logic [2:0] MODE_1920X1080 = 3'd5;

  typedef enum logic [2:0] {
    S_RUN,
    S_WAIT_FRAME,
    S_SWITCH,
    S_LOCK,
    S_RELEASE,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [2:0]  clk_sel;
    logic [11:0] htt;
    logic [11:0] hst;
    logic [11:0] hbp;
    logic [11:0] hvt;
    logic [11:0] vtt;
    logic [11:0] vst;
    logic [11:0] vbp;
    logic [11:0] vvt;
    logic [11:0] corber;
  } mode_cfg_t;

endpackage

// File: rtl/vga_mode_rom.sv
// Mode to pixel-clock select and timing parameter lookup.
// Unknown modes fall back to the 800x600 set and raise invalid.
module vga_mode_rom
  import vga_mode_pkg::*;
(
  input  logic [2:0] mode,
  output mode_cfg_t  cfg,
  output logic       invalid
);

  always_comb begin
    invalid = (mode >= 3'(MODE_CNT));
    cfg = '{3'd1, 12'd1039, 12'd120, 12'd64, 12'd800,
            12'd665, 12'd6, 12'd23, 12'd600, 12'd100};
    unique case (mode)
      MODE_640X480:
        cfg = '{3'd0, 12'd799, 12'd96, 12'd48, 12'd640,
                12'd524, 12'd2, 12'd33, 12'd480, 12'd80};
      MODE_800X600:
        cfg = '{3'd1, 12'd1039, 12'd120, 12'd64, 12'd800,
                12'd665, 12'd6, 12'd23, 12'd600, 12'd100};
      MODE_1024X768:
        cfg = '{3'd2, 12'd1343, 12'd136, 12'd160, 12'd1024,
                12'd805, 12'd6, 12'd29, 12'd768, 12'd128};
      MODE_1280X960:
        cfg = '{3'd3, 12'd1799, 12'd112, 12'd312, 12'd1280,
                12'd999, 12'd3, 12'd36, 12'd960, 12'd160};
      MODE_1280X1024:
        cfg = '{3'd4, 12'd1687, 12'd112, 12'd248, 12'd1280,
                12'd1065, 12'd3, 12'd38, 12'd1024, 12'd160};
      MODE_1920X1080:
        cfg = '{3'd5, 12'd1999, 12'd12, 12'd40, 12'd1920,
                12'd1104, 12'd4, 12'd18, 12'd1080, 12'd240};
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_mode_sequencer.sv
// Run-time video mode switcher: frame-aligned blanking, timing
// generator hold, pixel clock select and PLL settle supervision.
module vga_mode_sequencer
  import vga_mode_pkg::*;
#(
  parameter logic [2:0]  DEFAULT_MODE = 3'd1,
  parameter logic [7:0]  SETTLE_CYC   = 8'd64,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd500000
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        mode_req,
  input  logic [2:0]  mode_sel,
  output logic        mode_ack,
  output logic        mode_err,
  output logic        busy,
  input  logic        frame_end,
  input  logic        pll_locked,
  output logic [2:0]  clk_sel,
  output logic        tg_rst,
  output logic        blank,
  output logic [2:0]  cur_mode,
  output logic [11:0] htt,
  output logic [11:0] hst,
  output logic [11:0] hbp,
  output logic [11:0] hvt,
  output logic [11:0] vtt,
  output logic [11:0] vst,
  output logic [11:0] vbp,
  output logic [11:0] vvt,
  output logic [11:0] corber
);

  state_t      state;
  logic [2:0]  pend;
  logic        from_req;
  logic [7:0]  settle_cnt;
  logic [19:0] tmo_cnt;
  mode_cfg_t   cfg;
  mode_cfg_t   rom_cfg;
  logic        rom_bad;
  logic [2:0]  rom_mode;

  // ROM validates live requests, except when loading a mode
  always_comb begin
    rom_mode = mode_sel;
    if (rst)
      rom_mode = DEFAULT_MODE;
    else if (state == S_SWITCH)
      rom_mode = pend;
  end

  vga_mode_rom u_rom (
    .mode    (rom_mode),
    .cfg     (rom_cfg),
    .invalid (rom_bad)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state      <= S_LOCK;
      pend       <= DEFAULT_MODE;
      from_req   <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      cfg        <= rom_cfg;
      cur_mode   <= DEFAULT_MODE;
      tg_rst     <= 1'b1;
      blank      <= 1'b1;
      busy       <= 1'b1;
      mode_ack   <= 1'b0;
      mode_err   <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      mode_err <= 1'b0;
      unique case (state)
        S_RUN: begin
          if (!pll_locked) begin
            state      <= S_LOCK;
            tg_rst     <= 1'b1;
            blank      <= 1'b1;
            busy       <= 1'b1;
            from_req   <= 1'b0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
          end else if (mode_req && !busy) begin
            if (rom_bad) begin
              mode_ack <= 1'b1;
              mode_err <= 1'b1;
            end else if (mode_sel == cur_mode) begin
              mode_ack <= 1'b1;
            end else begin
              pend     <= mode_sel;
              from_req <= 1'b1;
              busy     <= 1'b1;
              state    <= S_WAIT_FRAME;
            end
          end
        end
        S_WAIT_FRAME: begin
          if (frame_end)
            state <= S_SWITCH;
        end
        S_SWITCH: begin
          cfg        <= rom_cfg;
          cur_mode   <= pend;
          tg_rst     <= 1'b1;
          blank      <= 1'b1;
          settle_cnt <= '0;
          tmo_cnt    <= '0;
          state      <= S_LOCK;
        end
        S_LOCK: begin
          if (settle_cnt == SETTLE_CYC) begin
            tg_rst <= 1'b0;
            state  <= S_RELEASE;
          end else if (tmo_cnt == LOCK_TIMEOUT) begin
            mode_err <= 1'b1;
            state    <= S_FAULT;
          end else begin
            settle_cnt <= pll_locked ? settle_cnt + 8'd1 : '0;
            tmo_cnt    <= tmo_cnt + 20'd1;
          end
        end
        S_RELEASE: begin
          if (frame_end) begin
            blank    <= 1'b0;
            busy     <= 1'b0;
            mode_ack <= from_req;
            from_req <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_FAULT: begin
          mode_err <= 1'b1;
          if (mode_req) begin
            if (rom_bad) begin
              mode_ack <= 1'b1;
            end else begin
              mode_err <= 1'b0;
              pend     <= mode_sel;
              from_req <= 1'b1;
              state    <= S_SWITCH;
            end
          end
        end
        default: state <= S_LOCK;
      endcase
    end
  end

  assign clk_sel = cfg.clk_sel;
  assign htt     = cfg.htt;
  assign hst     = cfg.hst;
  assign hbp     = cfg.hbp;
  assign hvt     = cfg.hvt;
  assign vtt     = cfg.vtt;
  assign vst     = cfg.vst;
  assign vbp     = cfg.vbp;
  assign vvt     = cfg.vvt;
  assign corber  = cfg.corber;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer against a
// table-driven model of mode switching and PLL settle rules.
module tb_vga_mode_sequencer;

  localparam int SETTLE = 64;
  localparam int TMO    = 400;

  logic        clk_50m = 1'b0;
  logic        rst = 1'b1;
  logic        mode_req = 1'b0;
  logic [2:0]  mode_sel = 3'd0;
  logic        frame_end = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mode_ack, mode_err, busy, tg_rst, blank;
  logic [2:0]  clk_sel, cur_mode;
  logic [11:0] htt, hst, hbp, hvt, vtt, vst, vbp, vvt, corber;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_mode = 1;

  vga_mode_sequencer #(
    .DEFAULT_MODE (3'd1),
    .SETTLE_CYC   (8'd64),
    .LOCK_TIMEOUT (20'd400)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .mode_req   (mode_req),
    .mode_sel   (mode_sel),
    .mode_ack   (mode_ack),
    .mode_err   (mode_err),
    .busy       (busy),
    .frame_end  (frame_end),
    .pll_locked (pll_locked),
    .clk_sel    (clk_sel),
    .tg_rst     (tg_rst),
    .blank      (blank),
    .cur_mode   (cur_mode),
    .htt        (htt),
    .hst        (hst),
    .hbp        (hbp),
    .hvt        (hvt),
    .vtt        (vtt),
    .vst        (vst),
    .vbp        (vbp),
    .vvt        (vvt),
    .corber     (corber)
  );

  always #10 clk_50m = ~clk_50m;

  // clk_sel, HTT HST HBP HVT, VTT VST VBP VVT, CORBER
  int ref_tab [6][10] = '{
    '{0,  799,  96,  48,  640,  524, 2, 33,  480,  80},
    '{1, 1039, 120,  64,  800,  665, 6, 23,  600, 100},
    '{2, 1343, 136, 160, 1024,  805, 6, 29,  768, 128},
    '{3, 1799, 112, 312, 1280,  999, 3, 36,  960, 160},
    '{4, 1687, 112, 248, 1280, 1065, 3, 38, 1024, 160},
    '{5, 1999,  12,  40, 1920, 1104, 4, 18, 1080, 240}
  };

  function automatic logic [110:0] ref_cfg(input int m);
    ref_cfg = {3'(ref_tab[m][0]),
               12'(ref_tab[m][1]), 12'(ref_tab[m][2]),
               12'(ref_tab[m][3]), 12'(ref_tab[m][4]),
               12'(ref_tab[m][5]), 12'(ref_tab[m][6]),
               12'(ref_tab[m][7]), 12'(ref_tab[m][8]),
               12'(ref_tab[m][9])};
  endfunction

  function automatic logic [110:0] obs_cfg();
    obs_cfg = {clk_sel, htt, hst, hbp, hvt,
               vtt, vst, vbp, vvt, corber};
  endfunction

  function automatic bit lock_at(input int j, input int gs,
                                 input int gl);
    lock_at = !(gl > 0 && j >= gs && j < gs + gl);
  endfunction

  task automatic tick();
    @(negedge clk_50m);
  endtask

  task automatic test_reset(input string tag);
    rst = 1'b1;
    mode_req = 1'b0;
    frame_end = 1'b0;
    pll_locked = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({tg_rst, blank, busy, mode_ack, mode_err} !== 5'b11100) begin
      n_fail++;
      $display("FAIL %s_ctl got %b exp 11100", tag,
               {tg_rst, blank, busy, mode_ack, mode_err});
    end
    n_checks++;
    if (obs_cfg() !== ref_cfg(1)) begin
      n_fail++;
      $display("FAIL %s_cfg got %h exp %h", tag, obs_cfg(), ref_cfg(1));
    end
    n_checks++;
    if (cur_mode !== 3'd1) begin
      n_fail++;
      $display("FAIL %s_mode got %0d exp 1", tag, cur_mode);
    end
    exp_mode = 1;
  endtask

  task automatic test_boot(input string tag);
    int n;
    int acks;
    int early;
    rst = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    acks = 0;
    early = 0;
    do begin
      tick();
      n++;
      acks += int'(mode_ack);
      if (blank !== 1'b1) early++;
    end while (tg_rst === 1'b1 && n < 200);
    n_checks++;
    if (n !== SETTLE + 1) begin
      n_fail++;
      $display("FAIL %s_settle got %0d exp %0d", tag, n, SETTLE + 1);
    end
    repeat ($urandom_range(0, 5)) begin
      tick();
      acks += int'(mode_ack);
      if (blank !== 1'b1) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL %s_blank_early got %0d exp 0", tag, early);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    acks += int'(mode_ack);
    n_checks++;
    if ({blank, busy, tg_rst} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_release got %b exp 000", tag,
               {blank, busy, tg_rst});
    end
    tick();
    acks += int'(mode_ack);
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL %s_no_ack got %0d exp 0", tag, acks);
    end
    n_checks++;
    if (obs_cfg() !== ref_cfg(1) || cur_mode !== 3'd1) begin
      n_fail++;
      $display("FAIL %s_cfg got %h exp %h", tag, obs_cfg(), ref_cfg(1));
    end
    exp_mode = 1;
  endtask

  task automatic do_switch(input string tag, input int m,
                           input int fe_gap, input int gs,
                           input int gl, input bit from_fault,
                           input bit noise);
    int n;
    int acks;
    int exp_n;
    int run;
    int bad;
    logic [110:0] old;
    old = ref_cfg(exp_mode);
    run = 0;
    exp_n = -1;
    for (int j = 0; j < 400 && exp_n < 0; j++) begin
      run = lock_at(j, gs, gl) ? run + 1 : 0;
      if (run == SETTLE) exp_n = j + 2;
    end
    mode_sel = 3'(m);
    mode_req = 1'b1;
    pll_locked = 1'b1;
    frame_end = !from_fault;
    tick();
    mode_req = 1'b0;
    frame_end = 1'b0;
    n_checks++;
    if ({busy, mode_ack, mode_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_accept got %b exp 100", tag,
               {busy, mode_ack, mode_err});
    end
    if (!from_fault) begin
      bad = 0;
      for (int i = 0; i < fe_gap; i++) begin
        tick();
        if (tg_rst !== 1'b0 || obs_cfg() !== old) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL %s_wait_hold got %0d exp 0", tag, bad);
      end
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
    end
    tick();
    n_checks++;
    if ({tg_rst, blank} !== 2'b11 || obs_cfg() !== ref_cfg(m)) begin
      n_fail++;
      $display("FAIL %s_load got %b/%h exp 11/%h", tag,
               {tg_rst, blank}, obs_cfg(), ref_cfg(m));
    end
    n_checks++;
    if (cur_mode !== 3'(m)) begin
      n_fail++;
      $display("FAIL %s_cur got %0d exp %0d", tag, cur_mode, m);
    end
    n = 0;
    acks = 0;
    bad = 0;
    pll_locked = lock_at(0, gs, gl);
    do begin
      if (noise) begin
        mode_req = 1'($urandom_range(0, 1));
        mode_sel = 3'($urandom_range(0, 7));
        frame_end = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
      acks += int'(mode_ack);
      if (blank !== 1'b1) bad++;
      pll_locked = lock_at(n, gs, gl);
    end while (tg_rst === 1'b1 && n < 400);
    mode_req = 1'b0;
    frame_end = 1'b0;
    pll_locked = 1'b1;
    n_checks++;
    if (n !== exp_n) begin
      n_fail++;
      $display("FAIL %s_settle got %0d exp %0d", tag, n, exp_n);
    end
    repeat ($urandom_range(0, 4)) begin
      tick();
      acks += int'(mode_ack);
      if (blank !== 1'b1) bad++;
    end
    n_checks++;
    if (acks !== 0 || bad !== 0) begin
      n_fail++;
      $display("FAIL %s_busy_quiet got ack=%0d blank_low=%0d exp 0/0",
               tag, acks, bad);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if ({mode_ack, mode_err, busy, blank, tg_rst} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s_done got %b exp 10000", tag,
               {mode_ack, mode_err, busy, blank, tg_rst});
    end
    tick();
    n_checks++;
    if (mode_ack !== 1'b0 || obs_cfg() !== ref_cfg(m)) begin
      n_fail++;
      $display("FAIL %s_after got ack=%b cfg=%h exp 0/%h", tag,
               mode_ack, obs_cfg(), ref_cfg(m));
    end
    exp_mode = m;
  endtask

  task automatic test_switch();
    do_switch("sw_1_2", 2, 3, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lock_glitch();
    do_switch("glitch", 4, 2, 40, 3, 1'b0, 1'b0);
  endtask

  task automatic test_invalid(input int m);
    logic [110:0] old;
    old = ref_cfg(exp_mode);
    mode_sel = 3'(m);
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    n_checks++;
    if ({mode_ack, mode_err, busy} !== 3'b110 || obs_cfg() !== old) begin
      n_fail++;
      $display("FAIL invalid_%0d got %b exp 110", m,
               {mode_ack, mode_err, busy});
    end
    tick();
    n_checks++;
    if ({mode_ack, mode_err, busy} !== 3'b000 ||
        cur_mode !== 3'(exp_mode)) begin
      n_fail++;
      $display("FAIL invalid_pulse got %b mode %0d exp 000 mode %0d",
               {mode_ack, mode_err, busy}, cur_mode, exp_mode);
    end
  endtask

  task automatic test_same_mode();
    mode_sel = 3'(exp_mode);
    mode_req = 1'b1;
    tick();
    n_checks++;
    if ({mode_ack, mode_err, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL same_ack got %b exp 100",
               {mode_ack, mode_err, busy});
    end
    tick();
    mode_req = 1'b0;
    n_checks++;
    if (mode_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL same_reack got %b exp 1", mode_ack);
    end
    tick();
    n_checks++;
    if ({mode_ack, busy, tg_rst, blank} !== 4'b0000) begin
      n_fail++;
      $display("FAIL same_idle got %b exp 0000",
               {mode_ack, busy, tg_rst, blank});
    end
  endtask

  task automatic test_lock_timeout();
    int n;
    int acks;
    pll_locked = 1'b0;
    tick();
    n = 1;
    acks = 0;
    n_checks++;
    if ({tg_rst, blank, busy, mode_ack} !== 4'b1110 ||
        obs_cfg() !== ref_cfg(exp_mode)) begin
      n_fail++;
      $display("FAIL lockloss got %b exp 1110",
               {tg_rst, blank, busy, mode_ack});
    end
    do begin
      tick();
      n++;
      acks += int'(mode_ack);
    end while (mode_err !== 1'b1 && n < TMO + 50);
    n_checks++;
    if (n !== TMO + 2 || acks !== 0) begin
      n_fail++;
      $display("FAIL timeout got %0d ack=%0d exp %0d ack=0",
               n, acks, TMO + 2);
    end
    tick();
    n_checks++;
    if ({mode_err, busy, tg_rst, blank} !== 4'b1111) begin
      n_fail++;
      $display("FAIL fault_hold got %b exp 1111",
               {mode_err, busy, tg_rst, blank});
    end
    mode_sel = 3'd7;
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    n_checks++;
    if ({mode_ack, mode_err, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL fault_invalid got %b exp 111",
               {mode_ack, mode_err, busy});
    end
    tick();
    n_checks++;
    if ({mode_ack, mode_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL fault_invalid_pulse got %b exp 01",
               {mode_ack, mode_err});
    end
    do_switch("fault_sw", 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int m;
    for (int k = 0; k < 8; k++) begin
      m = int'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) tick();
      if (m > 5)
        test_invalid(m);
      else if (m == exp_mode)
        test_same_mode();
      else
        do_switch("rand", m, int'($urandom_range(1, 6)),
                  int'($urandom_range(1, 60)),
                  ($urandom_range(0, 1) != 0) ?
                    int'($urandom_range(1, 4)) : 0,
                  1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int m;
    m = (exp_mode == 3) ? 4 : 3;
    mode_sel = 3'(m);
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (22) tick();
    mode_req = 1'b1;
    tick();
    test_reset("rst_mid");
    test_boot("rst_mid_boot");
  endtask

  initial begin
    test_reset("reset");
    test_boot("boot");
    test_switch();
    test_lock_glitch();
    test_invalid(6);
    test_same_mode();
    test_lock_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
